// File: rtl/adc_spi_cap.sv
// adc_spi_cap: SPI capture engine for one or more serial ADCs sharing a chip
// select. Each conversion is a LEAD/SHIFT/TRAIL frame with cs low, then a
// QUIET gap. All channels are published to dataout together, with a one-clock
// valid pulse.
module adc_spi_cap #(
   parameter int unsigned RES      = 8,
   parameter int unsigned CHANNELS = 1,
   parameter int unsigned LEAD     = 3,
   parameter int unsigned TRAIL    = 5,
   parameter int unsigned QUIET    = 4,
   parameter bit          INVERT   = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      cont,
   input  logic [CHANNELS-1:0]       miso,
   output logic                      cs,
   output logic [CHANNELS*RES-1:0]   dataout,
   output logic                      valid,
   output logic                      busy
);

   // One down-counter serves every phase; 4 bits cover RES-1 and QUIET up to 15.
   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_SHIFT,
      S_TRAIL,
      S_QUIET
   } state_e;

   localparam logic [CW-1:0] LEAD_LD   = CW'((LEAD > 0) ? LEAD - 1 : 0);
   localparam logic [CW-1:0] RES_LD    = CW'(RES - 1);
   localparam logic [CW-1:0] TRAIL_LD  = CW'((TRAIL > 0) ? TRAIL - 1 : 0);
   localparam logic [CW-1:0] QUIET_LD  = CW'(QUIET - 1);
   localparam logic [CW-1:0] QUIET_RST = CW'(QUIET);
   // A zero-length LEAD phase skips straight into SHIFT.
   localparam state_e        LAUNCH_ST  = (LEAD == 0) ? S_SHIFT : S_LEAD;
   localparam logic [CW-1:0] LAUNCH_CNT = (LEAD == 0) ? RES_LD : LEAD_LD;

   state_e                           state_q, state_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic                             cs_q, cs_d;
   logic                             valid_q, valid_d;
   logic                             busy_q, busy_d;
   logic [CHANNELS-1:0][RES-1:0]     sh_q, sh_d;
   logic [CHANNELS-1:0][RES-1:0]     data_q, data_d;
   logic [CHANNELS-1:0][RES-1:0]     sh_next_c;
   logic [RES:0]                     cat_c;

   // Every shift register takes its channel's next bit (MSB first) on the same edge.
   always_comb begin
      cat_c     = '0;
      sh_next_c = sh_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         cat_c        = {sh_q[i], miso[i] ^ INVERT};
         sh_next_c[i] = cat_c[RES-1:0];
      end
   end

   // Next-state logic: phase sequencing, counter reload, and word publication when cs rises.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cs_d    = cs_q;
      valid_d = 1'b0;
      sh_d    = sh_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE: begin
            if (start | cont) begin
               cs_d    = 1'b0;
               state_d = LAUNCH_ST;
               cnt_d   = LAUNCH_CNT;
            end
         end

         S_LEAD: begin
            if (cnt_q == '0) begin
               state_d = S_SHIFT;
               cnt_d   = RES_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_SHIFT: begin
            sh_d = sh_next_c;
            if (cnt_q == '0) begin
               if (TRAIL == 0) begin
                  // The last bit lands on the same edge that releases cs.
                  cs_d    = 1'b1;
                  valid_d = 1'b1;
                  data_d  = sh_next_c;
                  state_d = S_QUIET;
                  cnt_d   = QUIET_LD;
               end else begin
                  state_d = S_TRAIL;
                  cnt_d   = TRAIL_LD;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_TRAIL: begin
            if (cnt_q == '0) begin
               cs_d    = 1'b1;
               valid_d = 1'b1;
               data_d  = sh_q;
               state_d = S_QUIET;
               cnt_d   = QUIET_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         S_QUIET: begin
            // The final quiet clock also serves as the idle sampling edge,
            // so back-to-back conversions keep cs high for exactly QUIET clocks.
            if (cnt_q == '0) begin
               if (start | cont) begin
                  cs_d    = 1'b0;
                  state_d = LAUNCH_ST;
                  cnt_d   = LAUNCH_CNT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         default: begin
            state_d = S_QUIET;
            cnt_d   = QUIET_RST;
            cs_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset aborts any frame and parks the engine in QUIET.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_QUIET;
         cnt_q   <= QUIET_RST;
         cs_q    <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b1;
         sh_q    <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cs_q    <= cs_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
      end
   end

   assign cs      = cs_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign dataout = data_q;

endmodule

// File: tb/tb_adc_spi_cap.sv
// Bench for adc_spi_cap. One instance runs with default parameters. A second
// instance is a 4-channel, 12-bit, non-inverting engine with zero lead and trail
// and one quiet clock. A bus-functional ADC model chooses a word at each cs fall
// and queues the expected sample. The sample is checked when valid pulses.
module tb_adc_spi_cap;

   localparam int A_RES = 8;
   localparam int A_L   = 3;
   localparam int A_T   = 5;
   localparam int A_Q   = 4;
   localparam int B_RES = 12;
   localparam int B_CH  = 4;
   localparam int B_Q   = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_a, cont_a, cs_a, valid_a, busy_a;
   logic [0:0]  miso_a = '0;
   logic [7:0]  dout_a;
   logic        start_b, cont_b, cs_b, valid_b, busy_b;
   logic [3:0]  miso_b = '0;
   logic [47:0] dout_b;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adc_spi_cap u_dut_a (
      .clk     (clk),
      .reset   (reset),
      .start   (start_a),
      .cont    (cont_a),
      .miso    (miso_a),
      .cs      (cs_a),
      .dataout (dout_a),
      .valid   (valid_a),
      .busy    (busy_a)
   );

   adc_spi_cap #(
      .RES(B_RES), .CHANNELS(B_CH), .LEAD(0), .TRAIL(0), .QUIET(B_Q), .INVERT(1'b0)
   ) u_dut_b (
      .clk     (clk),
      .reset   (reset),
      .start   (start_b),
      .cont    (cont_b),
      .miso    (miso_b),
      .cs      (cs_b),
      .dataout (dout_b),
      .valid   (valid_b),
      .busy    (busy_b)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- ADC model + scoreboard, instance A ----------------
   logic [7:0] a_words[$];
   logic [7:0] a_exp_q[$];
   logic [7:0] a_word = '0;
   logic [7:0] a_exp;
   int         a_lo = 0, a_falls = 0, a_nval = 0;
   logic       a_prev = 1'b1;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         a_lo   = 0;
         a_prev = 1'b1;
         miso_a = '0;
      end else begin
         if (valid_a === 1'b1) begin
            a_nval++;
            if (a_exp_q.size() == 0) check("a_valid_spurious", 64'(valid_a), 64'(0));
            else begin
               a_exp = a_exp_q.pop_front();
               check("a_dataout", 64'(dout_a), 64'(a_exp));
            end
         end
         if (cs_a === 1'b0) begin
            if (a_prev) begin
               a_falls++;
               a_word = (a_words.size() > 0) ? a_words.pop_front() : 8'($urandom);
               a_exp_q.push_back(~a_word);
               a_lo = 0;
            end
            a_lo++;
            if (a_lo >= A_L + 1 && a_lo <= A_L + A_RES) miso_a[0] = a_word[A_RES - a_lo + A_L];
            else miso_a[0] = 1'($urandom);
         end else begin
            if (!a_prev) check("a_cs_low_len", 64'(a_lo), 64'(A_L + A_RES + A_T));
            miso_a[0] = 1'($urandom);
         end
         a_prev = cs_a;
      end
   end

   // ---------------- ADC model + scoreboard, instance B ----------------
   logic [11:0] b_w[B_CH];
   logic [47:0] b_exp_q[$];
   logic [47:0] b_exp, b_got;
   int          b_lo = 0, b_falls = 0, b_nval = 0, b_conv = 0;
   logic        b_prev = 1'b1;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         b_lo   = 0;
         b_prev = 1'b1;
         miso_b = '0;
      end else begin
         if (valid_b === 1'b1) begin
            b_nval++;
            if (b_exp_q.size() == 0) check("b_valid_spurious", 64'(valid_b), 64'(0));
            else begin
               b_got = b_exp_q.pop_front();
               check("b_dataout", 64'(dout_b), 64'(b_got));
            end
         end
         if (cs_b === 1'b0) begin
            if (b_prev) begin
               b_falls++;
               b_exp = '0;
               for (int i = 0; i < B_CH; i++) begin
                  b_w[i] = (b_conv == 0) ? 12'(32'h100 * i + 32'h00F) : 12'($urandom);
                  b_exp[i*B_RES +: B_RES] = b_w[i];
               end
               b_exp_q.push_back(b_exp);
               b_conv++;
               b_lo = 0;
            end
            b_lo++;
            for (int i = 0; i < B_CH; i++) begin
               if (b_lo >= 1 && b_lo <= B_RES) miso_b[i] = b_w[i][B_RES - b_lo];
               else miso_b[i] = 1'($urandom);
            end
         end else begin
            if (!b_prev) check("b_cs_low_len", 64'(b_lo), 64'(B_RES));
            miso_b = 4'($urandom);
         end
         b_prev = cs_b;
      end
   end

   // Wait (bounded) until the selected cs is observed at the requested level on a falling edge.
   task automatic wait_cs(input bit sel_b, input logic lvl, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((sel_b ? cs_b : cs_a) !== lvl) && n < 400);
      if (n >= 400) check({tag, "_timeout"}, 64'(n), 64'(0));
   endtask

   // Hard stop if the sequence ever wedges.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t1, t2, t3, f0, v0;
      reset   = 1'b0;
      start_a = 1'b0; cont_a = 1'b0;
      start_b = 1'b0; cont_b = 1'b0;
      a_words.push_back(8'h5A);

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("a_rst_cs",    64'(cs_a),    64'(1));
      check("a_rst_valid", 64'(valid_a), 64'(0));
      check("a_rst_busy",  64'(busy_a),  64'(1));
      check("a_rst_dout",  64'(dout_a),  64'(0));
      check("b_rst_cs",    64'(cs_b),    64'(1));
      check("b_rst_busy",  64'(busy_b),  64'(1));
      check("b_rst_dout",  64'(dout_b),  64'(0));

      // Single conversion of 0x5A; start is held from release until cs falls
      @(negedge clk);
      reset   = 1'b1;
      start_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_first_fall", n);
      check("a_rst_to_fall_ge_q1", 64'(n >= A_Q + 1), 64'(1));
      start_a = 1'b0;
      wait_cs(1'b0, 1'b1, "a_first_rise", n);
      n = 0;
      while (busy_a === 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("a_busy_quiet_clocks", 64'(n), 64'(A_Q));
      repeat (5) @(negedge clk);
      check("a_valid_count_single", 64'(a_nval), 64'(1));

      // Continuous mode: three conversions, cont dropped mid third
      f0 = a_falls; v0 = a_nval;
      cont_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_c1_fall", n); t1 = cyc;
      repeat (8) @(negedge clk);
      check("a_dout_hold_mid_shift", 64'(dout_a), 64'(8'hA5));
      wait_cs(1'b0, 1'b1, "a_c1_rise", n);
      wait_cs(1'b0, 1'b0, "a_c2_fall", n); t2 = cyc;
      check("a_cont_period_1", 64'(t2 - t1), 64'(20));
      wait_cs(1'b0, 1'b1, "a_c2_rise", n);
      wait_cs(1'b0, 1'b0, "a_c3_fall", n); t3 = cyc;
      check("a_cont_period_2", 64'(t3 - t2), 64'(20));
      repeat (5) @(negedge clk);
      cont_a = 1'b0;
      wait_cs(1'b0, 1'b1, "a_c3_rise", n);
      repeat (40) @(negedge clk);
      check("a_cont_falls",  64'(a_falls - f0), 64'(3));
      check("a_cont_valids", 64'(a_nval - v0),  64'(3));

      // Start held through one frame, released in QUIET: nothing queued
      f0 = a_falls; v0 = a_nval;
      start_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_h1_fall", n);
      wait_cs(1'b0, 1'b1, "a_h1_rise", n);
      start_a = 1'b0;
      repeat (40) @(negedge clk);
      check("a_held_no_queue_falls", 64'(a_falls - f0), 64'(1));
      check("a_held_valids",         64'(a_nval - v0),  64'(1));

      // Start still high at the first idle edge: back-to-back at 20 clocks
      f0 = a_falls;
      start_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_h2_fall", n); t1 = cyc;
      wait_cs(1'b0, 1'b1, "a_h2_rise", n);
      wait_cs(1'b0, 1'b0, "a_h3_fall", n); t2 = cyc;
      start_a = 1'b0;
      check("a_held_period", 64'(t2 - t1), 64'(20));
      wait_cs(1'b0, 1'b1, "a_h3_rise", n);
      repeat (40) @(negedge clk);
      check("a_held_falls", 64'(a_falls - f0), 64'(2));

      // Instance B: 4 channels x 12 bits, zero lead/trail, one quiet clock
      cont_b = 1'b1;
      wait_cs(1'b1, 1'b0, "b_1_fall", n); t1 = cyc;
      wait_cs(1'b1, 1'b1, "b_1_rise", n);
      wait_cs(1'b1, 1'b0, "b_2_fall", n); t2 = cyc;
      check("b_period_1", 64'(t2 - t1), 64'(B_RES + B_Q));
      wait_cs(1'b1, 1'b1, "b_2_rise", n);
      wait_cs(1'b1, 1'b0, "b_3_fall", n); t3 = cyc;
      check("b_period_2", 64'(t3 - t2), 64'(B_RES + B_Q));
      cont_b = 1'b0;
      wait_cs(1'b1, 1'b1, "b_3_rise", n);
      repeat (20) @(negedge clk);
      check("b_falls",  64'(b_falls), 64'(3));
      check("b_valids", 64'(b_nval),  64'(3));
      check("b_first_sample_pop", 64'(b_exp_q.size()), 64'(0));

      // Reset in the 6th SHIFT clock of A: abort without valid
      v0 = a_nval;
      start_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_r_fall", n);
      start_a = 1'b0;
      repeat (8) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("a_abort_cs",    64'(cs_a),    64'(1));
      check("a_abort_valid", 64'(valid_a), 64'(0));
      check("a_abort_busy",  64'(busy_a),  64'(1));
      check("a_abort_dout",  64'(dout_a),  64'(0));
      a_exp_q.delete();
      repeat (2) @(negedge clk);
      reset   = 1'b1;
      start_a = 1'b1;
      wait_cs(1'b0, 1'b0, "a_r2_fall", n);
      check("a_abort_fall_ge_q1", 64'(n >= A_Q + 1), 64'(1));
      start_a = 1'b0;
      wait_cs(1'b0, 1'b1, "a_r2_rise", n);
      repeat (10) @(negedge clk);
      check("a_abort_valids", 64'(a_nval - v0), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
